// File: rtl/ftdi_io_dec_seq_if.sv
// Signal bundle between the FTDI serial-in decoder sequencer and its environment.
// The master side drives control and data. The slave side is the sequencer, which drives strobes and the byte buffer.
interface ftdi_io_dec_seq_if #(
   parameter int CBits   = 8,
   parameter int CDivLen = 8
);
   logic               AEnable;
   logic [CDivLen-1:0] ADivI;
   logic               ASyncI;
   logic               AShiftEn;
   logic               ALatchEn;
   logic [CBits-1:0]   ADataI;
   logic [CBits-1:0]   AByteO;
   logic               AValidO;
   logic               AReadyI;
   logic               AOvfO;
   logic               AOvfClr;
   logic               ABusyO;

   modport master (
      output AEnable, ADivI, ASyncI, ADataI, AReadyI, AOvfClr,
      input  AShiftEn, ALatchEn, AByteO, AValidO, AOvfO, ABusyO
   );

   modport slave (
      input  AEnable, ADivI, ASyncI, ADataI, AReadyI, AOvfClr,
      output AShiftEn, ALatchEn, AByteO, AValidO, AOvfO, ABusyO
   );
endinterface

// File: rtl/ftdi_io_dec_seq.sv
// Shift/latch strobe sequencer and 1-entry byte buffer for the FTDI serial-in decoder.
// Build macro FTDI_IO_DEC_SEQ_AUTOSYNC_EN: frames run back-to-back after the first sync.
module ftdi_io_dec_seq #(
   parameter int CBits   = 8,
   parameter int CDivLen = 8
) (
   input logic              AClkH,
   input logic              AResetH,
   ftdi_io_dec_seq_if.slave io
);
   // state    | meaning
   // SIdle    | stopped, waiting for AEnable
   // SWait    | enabled, waiting for ASyncI
   // SShift   | divider running, one AShiftEn per bit period
   // SLatch   | single ALatchEn strobe
   // SCapture | latched byte offered to the output buffer

   localparam int CBitW = (CBits > 1) ? $clog2(CBits) : 1;
   localparam logic [CBitW-1:0]   CLastBit = CBitW'(CBits - 1);
   localparam logic [CBitW-1:0]   CBitOne  = CBitW'(1);
   localparam logic [CDivLen-1:0] CDivOne  = CDivLen'(1);

   typedef enum logic [2:0] {
      SIdle,
      SWait,
      SShift,
      SLatch,
      SCapture
   } tState;

   tState              state, stateNext;
   logic [CDivLen-1:0] divCnt, divCntNext;
   logic [CDivLen-1:0] divLat, divLatNext;
   logic [CBitW-1:0]   bitCnt, bitCntNext;
   logic               tick;
   logic               capture;
   logic               load;
   logic               overrun;
   logic [CBits-1:0]   byteBuf;
   logic               validBuf;
   logic               ovfBuf;

   always_ff @(posedge AClkH) begin
      if (AResetH) begin
         state  <= SIdle;
         divCnt <= '0;
         bitCnt <= '0;
         divLat <= '0;
      end else begin
         state  <= stateNext;
         divCnt <= divCntNext;
         bitCnt <= bitCntNext;
         divLat <= divLatNext;
      end
   end

   always_comb begin
      stateNext  = state;
      divCntNext = divCnt;
      bitCntNext = bitCnt;
      divLatNext = divLat;
      tick       = 1'b0;
      case (state)
         SIdle: begin
            if (io.AEnable) stateNext = SWait;
         end
         SWait: begin
            if (!io.AEnable) begin
               stateNext = SIdle;
            end else if (io.ASyncI) begin
               stateNext  = SShift;
               divCntNext = '0;
               bitCntNext = '0;
               divLatNext = io.ADivI;
            end
         end
         SShift: begin
            tick = (divCnt == divLat);
            if (tick) begin
               divCntNext = '0;
               bitCntNext = bitCnt + CBitOne;
               if (bitCnt == CLastBit) stateNext = SLatch;
            end else begin
               divCntNext = divCnt + CDivOne;
            end
         end
         SLatch: begin
            stateNext = SCapture;
         end
         SCapture: begin
`ifdef FTDI_IO_DEC_SEQ_AUTOSYNC_EN
            if (io.AEnable) begin
               stateNext  = SShift;
               divCntNext = '0;
               bitCntNext = '0;
               divLatNext = io.ADivI;
            end else begin
               stateNext = SIdle;
            end
`else
            stateNext = io.AEnable ? SWait : SIdle;
`endif
         end
         default: begin
            stateNext = SIdle;
         end
      endcase
   end

   // A full buffer is only replaced when the consumer takes the old byte in the same cycle.
   assign capture = (state == SCapture);
   assign load    = capture && (!validBuf || io.AReadyI);
   assign overrun = capture && validBuf && !io.AReadyI;

   always_ff @(posedge AClkH) begin
      if (AResetH) begin
         byteBuf  <= '0;
         validBuf <= 1'b0;
         ovfBuf   <= 1'b0;
      end else begin
         if (load) begin
            byteBuf  <= io.ADataI;
            validBuf <= 1'b1;
         end else if (validBuf && io.AReadyI) begin
            validBuf <= 1'b0;
         end
         if (overrun) begin
            ovfBuf <= 1'b1;
         end else if (io.AOvfClr) begin
            ovfBuf <= 1'b0;
         end
      end
   end

   assign io.AShiftEn = tick;
   assign io.ALatchEn = (state == SLatch);
   assign io.ABusyO   = (state == SShift) || (state == SLatch) || (state == SCapture);
   assign io.AByteO   = byteBuf;
   assign io.AValidO  = validBuf;
   assign io.AOvfO    = ovfBuf;

endmodule

// File: tb/tb_ftdi_io_dec_seq.sv
// Bench for ftdi_io_dec_seq: expected strobe cycles and bytes are queued at stimulus time
// and compared against what a negedge monitor records from the DUT.
module tb_ftdi_io_dec_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   edgeCnt  = 0;
   logic validPrev = 1'b0;

   int         shiftQ[$];
   int         latchQ[$];
   int         validRiseQ[$];
   int         expShiftQ[$];
   int         expLatchQ[$];
   int         expValidQ[$];
   logic [7:0] expByteQ[$];

   ftdi_io_dec_seq_if #(.CBits(8), .CDivLen(8)) io ();

   ftdi_io_dec_seq #(.CBits(8), .CDivLen(8)) dut (
      .AClkH  (clk),
      .AResetH(rst),
      .io     (io)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   // cycle index c = interval following posedge number c-1
   always @(negedge clk) begin
      if (io.AShiftEn === 1'b1) shiftQ.push_back(edgeCnt + 1);
      if (io.ALatchEn === 1'b1) latchQ.push_back(edgeCnt + 1);
      if (io.AValidO === 1'b1 && !validPrev) validRiseQ.push_back(edgeCnt + 1);
      validPrev <= (io.AValidO === 1'b1);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic clearObs();
      shiftQ.delete();
      latchQ.delete();
      validRiseQ.delete();
      expShiftQ.delete();
      expLatchQ.delete();
      expValidQ.delete();
      expByteQ.delete();
   endtask

   task automatic waitCycle(input int c);
      int guard = 0;
      while (edgeCnt + 1 < c && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 5000) begin
         checks++;
         failures++;
         $display("FAIL wait_cycle: reached %0d, required %0d", edgeCnt + 1, c);
      end
   endtask

   // Pulse ASyncI so it is sampled at edge k and queue the strobe cycles the frames must produce.
   task automatic startFrame(input logic [7:0] div, input int frames, output int k);
      int d;
      int p;
      int base;
      d = int'(div);
      p = 8 * (d + 1) + 2;
      io.ADivI  = div;
      k         = edgeCnt + 1;
      io.ASyncI = 1'b1;
      for (int f = 0; f < frames; f++) begin
         base = k + 1 + f * p;
         for (int n = 0; n < 8; n++) expShiftQ.push_back(base + n * (d + 1) + d);
         expLatchQ.push_back(base + 8 * (d + 1));
         expValidQ.push_back(base + 8 * (d + 1) + 2);
      end
      @(negedge clk);
      io.ASyncI = 1'b0;
   endtask

   task automatic test_reset();
      io.AEnable = 1'b1;
      io.ASyncI  = 1'b1;
      rst        = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({io.AShiftEn, io.ALatchEn} !== 2'b00) begin
         failures++;
         $display("FAIL reset_strobes: got %b, required 00", {io.AShiftEn, io.ALatchEn});
      end
      checks++;
      if (io.AByteO !== 8'h00) begin
         failures++;
         $display("FAIL reset_byte: got %h, required 00", io.AByteO);
      end
      checks++;
      if ({io.AValidO, io.AOvfO, io.ABusyO} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags: valid/ovf/busy got %b, required 000",
                  {io.AValidO, io.AOvfO, io.ABusyO});
      end
      io.ASyncI = 1'b0;
      rst       = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (io.ABusyO !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_busy: got %b, required 0", io.ABusyO);
      end
   endtask

   task automatic test_timing();
      int k;
      int e;
      int o;
      clearObs();
      io.AReadyI = 1'b0;
      io.ADataI  = 8'hFF;
      startFrame(8'd3, 1, k);
      io.ADivI = 8'd7;
      waitCycle(k + 34);
      io.ADataI = 8'h5A;
      expByteQ.push_back(8'h5A);
      @(negedge clk);
      io.ADataI = 8'hFF;
      waitCycle(k + 38);
      checks++;
      if (shiftQ.size() != 8) begin
         failures++;
         $display("FAIL t1_shift_count: got %0d, required 8", shiftQ.size());
      end
      while (expShiftQ.size() > 0 && shiftQ.size() > 0) begin
         e = expShiftQ.pop_front();
         o = shiftQ.pop_front();
         checks++;
         if (o != e) begin
            failures++;
            $display("FAIL t1_shift_cycle: got %0d, required %0d", o, e);
         end
      end
      e = expLatchQ.pop_front();
      o = (latchQ.size() == 1) ? latchQ.pop_front() : -1;
      checks++;
      if (o != e) begin
         failures++;
         $display("FAIL t1_latch_cycle: got %0d, required %0d", o, e);
      end
      e = expValidQ.pop_front();
      o = (validRiseQ.size() == 1) ? validRiseQ.pop_front() : -1;
      checks++;
      if (o != e) begin
         failures++;
         $display("FAIL t1_valid_cycle: got %0d, required %0d", o, e);
      end
      checks++;
      if (io.AByteO !== expByteQ[0]) begin
         failures++;
         $display("FAIL t1_byte: got %h, required %h", io.AByteO, expByteQ[0]);
      end
      void'(expByteQ.pop_front());
      checks++;
      if (io.ABusyO !== 1'b0) begin
         failures++;
         $display("FAIL t1_busy_after: got %b, required 0", io.ABusyO);
      end
      io.AReadyI = 1'b1;
      @(negedge clk);
      io.AReadyI = 1'b0;
      checks++;
      if (io.AValidO !== 1'b0) begin
         failures++;
         $display("FAIL t1_consume: valid got %b, required 0", io.AValidO);
      end
   endtask

   task automatic test_div_zero();
      int k;
      int e;
      int o;
      clearObs();
      io.ADataI = 8'h3C;
      expByteQ.push_back(8'h3C);
      startFrame(8'd0, 1, k);
      io.ADivI = 8'd5;
      waitCycle(k + 13);
      checks++;
      if (shiftQ.size() != 8) begin
         failures++;
         $display("FAIL t2_shift_count: got %0d, required 8", shiftQ.size());
      end
      while (expShiftQ.size() > 0 && shiftQ.size() > 0) begin
         e = expShiftQ.pop_front();
         o = shiftQ.pop_front();
         checks++;
         if (o != e) begin
            failures++;
            $display("FAIL t2_shift_cycle: got %0d, required %0d", o, e);
         end
      end
      e = expLatchQ.pop_front();
      o = (latchQ.size() == 1) ? latchQ.pop_front() : -1;
      checks++;
      if (o != e) begin
         failures++;
         $display("FAIL t2_latch_cycle: got %0d, required %0d", o, e);
      end
      checks++;
      if (io.AByteO !== expByteQ[0] || io.AValidO !== 1'b1) begin
         failures++;
         $display("FAIL t2_byte: got %h valid %b, required %h valid 1",
                  io.AByteO, io.AValidO, expByteQ[0]);
      end
      io.AReadyI = 1'b1;
      @(negedge clk);
      io.AReadyI = 1'b0;
   endtask

   task automatic test_overrun();
      int k;
      clearObs();
      io.AReadyI = 1'b0;
      io.ADataI  = 8'h11;
      startFrame(8'd0, 1, k);
      waitCycle(k + 12);
      io.ADataI = 8'h22;
      startFrame(8'd0, 1, k);
      waitCycle(k + 12);
      checks++;
      if (io.AByteO !== 8'h11 || io.AValidO !== 1'b1 || io.AOvfO !== 1'b1) begin
         failures++;
         $display("FAIL t3_overrun: byte %h valid %b ovf %b, required 11 1 1",
                  io.AByteO, io.AValidO, io.AOvfO);
      end
      io.AOvfClr = 1'b1;
      @(negedge clk);
      io.AOvfClr = 1'b0;
      checks++;
      if (io.AOvfO !== 1'b0) begin
         failures++;
         $display("FAIL t3_ovf_clear: got %b, required 0", io.AOvfO);
      end
      io.AOvfClr = 1'b1;
      io.ADataI  = 8'h44;
      startFrame(8'd0, 1, k);
      waitCycle(k + 10);
      @(negedge clk);
      checks++;
      if (io.AOvfO !== 1'b1 || io.AByteO !== 8'h11) begin
         failures++;
         $display("FAIL t3_set_wins: ovf %b byte %h, required 1 11", io.AOvfO, io.AByteO);
      end
      @(negedge clk);
      io.AOvfClr = 1'b0;
      io.ADataI  = 8'h33;
      expByteQ.push_back(8'h33);
      startFrame(8'd0, 1, k);
      waitCycle(k + 10);
      io.AReadyI = 1'b1;
      @(negedge clk);
      io.AReadyI = 1'b0;
      @(negedge clk);
      checks++;
      if (io.AByteO !== expByteQ[0] || io.AValidO !== 1'b1 || io.AOvfO !== 1'b0) begin
         failures++;
         $display("FAIL t3_ready_in_capture: byte %h valid %b ovf %b, required %h 1 0",
                  io.AByteO, io.AValidO, io.AOvfO, expByteQ[0]);
      end
      void'(expByteQ.pop_front());
      io.AReadyI = 1'b1;
      @(negedge clk);
      io.AReadyI = 1'b0;
   endtask

   task automatic test_enable_drop();
      int k;
      int e;
      int o;
      clearObs();
      io.ADataI = 8'h77;
      expByteQ.push_back(8'h77);
      startFrame(8'd2, 1, k);
      waitCycle(k + 9);
      io.AEnable = 1'b0;
      waitCycle(k + 30);
      checks++;
      if (shiftQ.size() != 8 || latchQ.size() != 1) begin
         failures++;
         $display("FAIL t4_counts: shifts %0d latches %0d, required 8 1", shiftQ.size(), latchQ.size());
      end
      while (expShiftQ.size() > 0 && shiftQ.size() > 0) begin
         e = expShiftQ.pop_front();
         o = shiftQ.pop_front();
         checks++;
         if (o != e) begin
            failures++;
            $display("FAIL t4_shift_cycle: got %0d, required %0d", o, e);
         end
      end
      checks++;
      if (io.AByteO !== expByteQ[0] || io.AValidO !== 1'b1 || io.ABusyO !== 1'b0) begin
         failures++;
         $display("FAIL t4_capture: byte %h valid %b busy %b, required %h 1 0",
                  io.AByteO, io.AValidO, io.ABusyO, expByteQ[0]);
      end
      void'(expByteQ.pop_front());
      clearObs();
      io.ASyncI = 1'b1;
      @(negedge clk);
      io.ASyncI = 1'b0;
      repeat (40) @(negedge clk);
      checks++;
      if (shiftQ.size() != 0 || latchQ.size() != 0 || io.ABusyO !== 1'b0) begin
         failures++;
         $display("FAIL t4_idle_sync: shifts %0d latches %0d busy %b, required 0 0 0",
                  shiftQ.size(), latchQ.size(), io.ABusyO);
      end
      io.AEnable = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int k;
      clearObs();
      io.ADataI = 8'h99;
      startFrame(8'd1, 1, k);
      waitCycle(k + 10);
      checks++;
      if (io.AShiftEn !== 1'b1) begin
         failures++;
         $display("FAIL t5_fifth_shift: got %b, required 1", io.AShiftEn);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({io.AShiftEn, io.ALatchEn, io.AValidO, io.AOvfO, io.ABusyO} !== 5'b00000 ||
          io.AByteO !== 8'h00) begin
         failures++;
         $display("FAIL t5_reset_outputs: shift/latch/valid/ovf/busy %b byte %h, required 00000 00",
                  {io.AShiftEn, io.ALatchEn, io.AValidO, io.AOvfO, io.ABusyO}, io.AByteO);
      end
      rst = 1'b0;
      repeat (25) @(negedge clk);
      checks++;
      if (latchQ.size() != 0 || io.AValidO !== 1'b0) begin
         failures++;
         $display("FAIL t5_no_capture: latches %0d valid %b, required 0 0", latchQ.size(), io.AValidO);
      end
   endtask

   task automatic test_autosync();
      int k;
      int e;
      int o;
      int nFrames;
      clearObs();
      io.AReadyI = 1'b1;
      io.ADataI  = 8'hA5;
`ifdef FTDI_IO_DEC_SEQ_AUTOSYNC_EN
      nFrames = 3;
`else
      nFrames = 1;
`endif
      startFrame(8'd1, nFrames, k);
      waitCycle(k + 60);
      checks++;
      if (shiftQ.size() < 8 * nFrames || latchQ.size() < nFrames) begin
         failures++;
         $display("FAIL t6_counts: shifts %0d latches %0d, required at least %0d %0d",
                  shiftQ.size(), latchQ.size(), 8 * nFrames, nFrames);
      end
      while (expShiftQ.size() > 0 && shiftQ.size() > 0) begin
         e = expShiftQ.pop_front();
         o = shiftQ.pop_front();
         checks++;
         if (o != e) begin
            failures++;
            $display("FAIL t6_shift_cycle: got %0d, required %0d", o, e);
         end
      end
      while (expLatchQ.size() > 0 && latchQ.size() > 0) begin
         e = expLatchQ.pop_front();
         o = latchQ.pop_front();
         checks++;
         if (o != e) begin
            failures++;
            $display("FAIL t6_latch_cycle: got %0d, required %0d", o, e);
         end
      end
`ifdef FTDI_IO_DEC_SEQ_AUTOSYNC_EN
      checks++;
      if (io.ABusyO !== 1'b1) begin
         failures++;
         $display("FAIL t6_still_running: busy got %b, required 1", io.ABusyO);
      end
`else
      checks++;
      if (shiftQ.size() != 0 || latchQ.size() != 0 || io.ABusyO !== 1'b0) begin
         failures++;
         $display("FAIL t6_single_frame: extra shifts %0d latches %0d busy %b, required 0 0 0",
                  shiftQ.size(), latchQ.size(), io.ABusyO);
      end
`endif
      io.AEnable = 1'b0;
      repeat (30) @(negedge clk);
      io.AEnable = 1'b1;
      io.AReadyI = 1'b0;
   endtask

   initial begin
      io.AEnable = 1'b0;
      io.ADivI   = 8'd0;
      io.ASyncI  = 1'b0;
      io.ADataI  = 8'h00;
      io.AReadyI = 1'b0;
      io.AOvfClr = 1'b0;
      @(negedge clk);
      test_reset();
      test_timing();
      test_div_zero();
      test_overrun();
      test_enable_drop();
      test_reset_mid();
      test_autosync();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
